// File: rtl/optical_flow_pkg.sv
// Shared widths, frame geometry and data types for the optical-flow tensor path.
// Tensor product saturation is selected by TENSOR_SATURATE_EN in scale_sat.
package optical_flow_pkg;
  localparam int FRAME_WIDTH  = 1024;
  localparam int FRAME_HEIGHT = 768;
  localparam int IN_BITS      = 12;
  localparam int OUT_BITS     = 16;
  localparam int SHIFT        = 8;
  localparam int BORDER       = 3;

  typedef logic signed [IN_BITS-1:0]  grad_t;
  typedef logic signed [OUT_BITS-1:0] prod_t;

  typedef struct packed {
    prod_t xx;
    prod_t xy;
    prod_t yy;
    prod_t xt;
    prod_t yt;
  } tensor_t;
endpackage

// File: rtl/tensor_products_if.sv
// Pixel stream in / tensor products out bundle for tensor_products.
interface tensor_products_if;
  import optical_flow_pkg::*;

  logic  en;
  grad_t t_in;
  grad_t x_in;
  grad_t y_in;
  prod_t xx_out;
  prod_t xy_out;
  prod_t yy_out;
  prod_t xt_out;
  prod_t yt_out;
  logic  valid_out;
  logic  sof_out;
  logic  eol_out;

  modport master (
    output en, t_in, x_in, y_in,
    input  xx_out, xy_out, yy_out, xt_out, yt_out, valid_out, sof_out, eol_out
  );

  modport slave (
    input  en, t_in, x_in, y_in,
    output xx_out, xy_out, yy_out, xt_out, yt_out, valid_out, sof_out, eol_out
  );
endinterface

// File: rtl/tensor_products_scale_sat.sv
// Floor shift of one full-precision product, then saturate (TENSOR_SATURATE_EN)
// or two's-complement wrap to the output width.
module scale_sat #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0]  p,
  output logic signed [OUT_W-1:0] q
);
  logic signed [IN_W-1:0] sh;

  // Arithmetic shift on a signed operand rounds toward -inf.
  assign sh = p >>> SHIFT;

`ifdef TENSOR_SATURATE_EN
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (sh > MAX_V)
      q = MAX_V[OUT_W-1:0];
    else if (sh < MIN_V)
      q = MIN_V[OUT_W-1:0];
    else
      q = sh[OUT_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^sh[IN_W-1:OUT_W];
  assign q         = sh[OUT_W-1:0];
`endif
endmodule

// File: rtl/tensor_products.sv
// Structure-tensor products Ixx/Ixy/Iyy/Ixt/Iyt, 3-stage en-stalled pipeline
// with raster tracking and border masking. Saturation via TENSOR_SATURATE_EN.
module tensor_products #(
  parameter int FRAME_WIDTH  = optical_flow_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = optical_flow_pkg::FRAME_HEIGHT,
  parameter int SHIFT        = optical_flow_pkg::SHIFT,
  parameter int BORDER       = optical_flow_pkg::BORDER
) (
  input logic             clk,
  input logic             rst,
  tensor_products_if.slave bus
);
  import optical_flow_pkg::*;

  localparam int CW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int PW = 2 * IN_BITS;
  localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

  logic [CW-1:0] col, col1;
  logic [RW-1:0] row, row1;
  grad_t         t1, x1, y1;
  logic          v1, v2, v3;
  logic          inside1, mask2, sof2, eol2, sof3, eol3;
  logic signed [PW-1:0] p_xx, p_xy, p_yy, p_xt, p_yt;
  tensor_t       scaled, res;

  assign inside1 = (int'(col1) >= BORDER) && (int'(col1) < FRAME_WIDTH - BORDER) &&
                   (int'(row1) >= BORDER) && (int'(row1) < FRAME_HEIGHT - BORDER);

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      col1 <= '0;
      row1 <= '0;
      t1   <= '0;
      x1   <= '0;
      y1   <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      p_xx <= '0;
      p_xy <= '0;
      p_yy <= '0;
      p_xt <= '0;
      p_yt <= '0;
      mask2 <= 1'b0;
      sof2 <= 1'b0;
      eol2 <= 1'b0;
      sof3 <= 1'b0;
      eol3 <= 1'b0;
      res  <= '0;
    end else if (bus.en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      // S1
      col1 <= col;
      row1 <= row;
      t1   <= bus.t_in;
      x1   <= bus.x_in;
      y1   <= bus.y_in;
      v1   <= 1'b1;
      // S2
      p_xx  <= PW'(x1) * PW'(x1);
      p_xy  <= PW'(x1) * PW'(y1);
      p_yy  <= PW'(y1) * PW'(y1);
      p_xt  <= PW'(x1) * PW'(t1);
      p_yt  <= PW'(y1) * PW'(t1);
      mask2 <= !inside1;
      sof2  <= (col1 == '0) && (row1 == '0);
      eol2  <= (col1 == COL_LAST);
      v2    <= v1;
      // S3
      res  <= mask2 ? '0 : scaled;
      sof3 <= sof2;
      eol3 <= eol2;
      v3   <= v2;
    end
  end

  scale_sat #(.IN_W(PW), .OUT_W(OUT_BITS), .SHIFT(SHIFT)) u_ss_xx (.p(p_xx), .q(scaled.xx));
  scale_sat #(.IN_W(PW), .OUT_W(OUT_BITS), .SHIFT(SHIFT)) u_ss_xy (.p(p_xy), .q(scaled.xy));
  scale_sat #(.IN_W(PW), .OUT_W(OUT_BITS), .SHIFT(SHIFT)) u_ss_yy (.p(p_yy), .q(scaled.yy));
  scale_sat #(.IN_W(PW), .OUT_W(OUT_BITS), .SHIFT(SHIFT)) u_ss_xt (.p(p_xt), .q(scaled.xt));
  scale_sat #(.IN_W(PW), .OUT_W(OUT_BITS), .SHIFT(SHIFT)) u_ss_yt (.p(p_yt), .q(scaled.yt));

  assign bus.xx_out    = res.xx;
  assign bus.xy_out    = res.xy;
  assign bus.yy_out    = res.yy;
  assign bus.xt_out    = res.xt;
  assign bus.yt_out    = res.yt;
  assign bus.valid_out = v3;
  assign bus.sof_out   = sof3;
  assign bus.eol_out   = eol3;
endmodule

// File: tb/tb_tensor_products.sv
// Scoreboard bench: two tensor_products instances (8x6 frame) with different
// SHIFT/BORDER, checked against an arithmetic reference model.
module tb_tensor_products;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic signed [11:0] x = '0, y = '0, t = '0;

  always #5 clk = ~clk;

  tensor_products_if if0 ();
  tensor_products_if if1 ();

  assign if0.en = en;  assign if0.x_in = x;  assign if0.y_in = y;  assign if0.t_in = t;
  assign if1.en = en;  assign if1.x_in = x;  assign if1.y_in = y;  assign if1.t_in = t;

  tensor_products #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SHIFT(0), .BORDER(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  tensor_products #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SHIFT(1), .BORDER(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct packed {
    logic [9:0][31:0] e;
    logic             sof;
    logic             eol;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   pidx   = 0;
  int   edges  = 0;

  logic signed [15:0] a0 [5];
  logic signed [15:0] a1 [5];
  assign a0[0] = if0.xx_out; assign a0[1] = if0.xy_out; assign a0[2] = if0.yy_out;
  assign a0[3] = if0.xt_out; assign a0[4] = if0.yt_out;
  assign a1[0] = if1.xx_out; assign a1[1] = if1.xy_out; assign a1[2] = if1.yy_out;
  assign a1[3] = if1.xt_out; assign a1[4] = if1.yt_out;

  logic [165:0] cur, snap;
  assign cur = {if0.xx_out, if0.xy_out, if0.yy_out, if0.xt_out, if0.yt_out,
                if0.valid_out, if0.sof_out, if0.eol_out,
                if1.xx_out, if1.xy_out, if1.yy_out, if1.xt_out, if1.yt_out,
                if1.valid_out, if1.sof_out, if1.eol_out};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // floor(p / 2^sh), then clamp or wrap to a signed 16-bit value
  function automatic longint scale(input longint p, input int sh);
    longint d, r;
    d = longint'(1) << sh;
    if (p >= 0) r = p / d;
    else        r = -((-p + d - 1) / d);
`ifdef TENSOR_SATURATE_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`else
    r = r % 65536;
    if (r < 0)      r += 65536;
    if (r >= 32768) r -= 65536;
`endif
    return r;
  endfunction

  function automatic exp_t model(input int xv, input int yv, input int tv, input int idx);
    exp_t   m;
    int     col, row, b, sh;
    longint pr [5];
    col = idx % W;
    row = idx / W;
    pr[0] = xv * xv; pr[1] = xv * yv; pr[2] = yv * yv; pr[3] = xv * tv; pr[4] = yv * tv;
    for (int d = 0; d < 2; d++) begin
      b  = d;
      sh = d;
      for (int k = 0; k < 5; k++) begin
        if (col < b || col >= W - b || row < b || row >= H - b)
          m.e[d*5+k] = 32'd0;
        else
          m.e[d*5+k] = 32'(scale(pr[k], sh));
      end
    end
    m.sof = (idx == 0);
    m.eol = (col == W - 1);
    return m;
  endfunction

  task automatic px(input bit e, input int xv, input int yv, input int tv);
    @(negedge clk);
    rst = 1'b0;
    en  = e;
    x   = 12'(xv); y = 12'(yv); t = 12'(tv);
    if (e) begin
      q.push_back(model(xv, yv, tv, pidx));
      pidx = (pidx + 1) % (W * H);
    end
  endtask

  task automatic do_reset(input bit e);
    @(negedge clk);
    rst = 1'b1;
    en  = e;
    pidx = 0;
  endtask

  // Monitor: every enabled edge advances the pipeline; compare popped expectation
  always @(posedge clk) begin
    automatic bit en_s  = en;
    automatic bit rst_s = rst;
    automatic exp_t m;
    #1;
    if (rst_s) begin
      q.delete();
      edges = 0;
      chk("reset_valid0", longint'(if0.valid_out), 0);
      chk("reset_valid1", longint'(if1.valid_out), 0);
      chk("reset_xx0", longint'(a0[0]), 0);
      chk("reset_flags", longint'({if0.sof_out, if0.eol_out, if1.sof_out, if1.eol_out}), 0);
    end else if (en_s) begin
      edges++;
      chk("valid0", longint'(if0.valid_out), longint'(edges >= 3));
      chk("valid1", longint'(if1.valid_out), longint'(edges >= 3));
      if (if0.valid_out) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          m = q.pop_front();
          for (int k = 0; k < 5; k++) begin
            chk($sformatf("dut0_p%0d", k), longint'(a0[k]), longint'($signed(m.e[k])));
            chk($sformatf("dut1_p%0d", k), longint'(a1[k]), longint'($signed(m.e[5+k])));
          end
          chk("sof0", longint'(if0.sof_out), longint'(m.sof));
          chk("eol0", longint'(if0.eol_out), longint'(m.eol));
          chk("sof1", longint'(if1.sof_out), longint'(m.sof));
          chk("eol1", longint'(if1.eol_out), longint'(m.eol));
        end
      end
    end else begin
      chk("hold", longint'(cur == snap), 1);
    end
    snap = cur;
  end

  initial begin
    int xv, yv, tv;
    repeat (2) @(negedge clk);

    // basic products with a stalling en pattern
    do_reset(1'b1);
    px(1, 10, -3, 4); px(0, 10, -3, 4); px(0, 10, -3, 4);
    px(1, 10, -3, 4); px(0, 10, -3, 4); px(1, 10, -3, 4);
    @(posedge clk); #2;
    chk("t1_xx", longint'(a0[0]), 100);
    chk("t1_xy", longint'(a0[1]), -30);
    chk("t1_yy", longint'(a0[2]), 9);
    chk("t1_xt", longint'(a0[3]), 40);
    chk("t1_yt", longint'(a0[4]), -12);
    chk("t1_sof", longint'(if0.sof_out), 1);
    px(0, 0, 0, 0); px(0, 0, 0, 0);

    // extreme negative inputs
    do_reset(1'b0);
    repeat (3) px(1, -2048, -2048, 0);
    @(posedge clk); #2;
`ifdef TENSOR_SATURATE_EN
    chk("sat_xx", longint'(a0[0]), 32767);
    chk("sat_xy", longint'(a0[1]), 32767);
`else
    chk("wrap_xx", longint'(a0[0]), 0);
    chk("wrap_xy", longint'(a0[1]), 0);
`endif

    // full frame of constant 5s plus one pixel into the next frame
    do_reset(1'b0);
    repeat (W * H + 4) px(1, 5, 5, 5);

    // reset mid-frame at pixel (3,2), then restart
    do_reset(1'b0);
    repeat (2 * W + 3) px(1, 7, -1, 2);
    do_reset(1'b1);
    repeat (3) px(1, 3, 4, -5);
    px(0, 0, 0, 0);

    // randomized data and en pattern, including small values for floor checks
    do_reset(1'b0);
    repeat (400) begin
      if ($urandom_range(3) == 0) begin
        xv = int'($urandom_range(2)) - 1;
        yv = int'($urandom_range(2)) - 1;
        tv = int'($urandom_range(2)) - 1;
      end else begin
        xv = int'($urandom_range(4095)) - 2048;
        yv = int'($urandom_range(4095)) - 2048;
        tv = int'($urandom_range(4095)) - 2048;
      end
      px(1'($urandom_range(1)), xv, yv, tv);
    end
    repeat (4) px(1, 0, 0, 0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tensor_products.md
Name: tensor_products

Overview:
- Directly downstream of the temporal+spatial gradient smoothing stage.
- Consumes the smoothed t/x/y gradient streams, one pixel per enabled cycle, in raster order.
- Produces the five structure-tensor products Ixx, Ixy, Iyy, Ixt, Iyt that feed the tensor smoothing and flow-solve stages.
- Pipelined and enable-stalled. Tracks raster position so that pixels with invalid upstream smoothing windows can be masked to zero.

Parameters:
- FRAME_WIDTH, 1024, pixels per line.
- FRAME_HEIGHT, 768, lines per frame.
- IN_BITS, 12, width of each signed gradient input; matches the upstream spatial output width.
- OUT_BITS, 16, width of each signed product output.
- SHIFT, 8, arithmetic right shift applied to the full 2*IN_BITS product before saturation.
- BORDER, 3, pixel margin on every frame edge treated as invalid. Equals (upstream spatial kernel size + 1)/2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pixel enable; one input pixel is accepted and the pipeline advances only when en=1.
- t_in  in  IN_BITS  signed smoothed temporal gradient.
- x_in  in  IN_BITS  signed smoothed x gradient.
- y_in  in  IN_BITS  signed smoothed y gradient.
- xx_out  out  OUT_BITS  signed Ix*Ix.
- xy_out  out  OUT_BITS  signed Ix*Iy.
- yy_out  out  OUT_BITS  signed Iy*Iy.
- xt_out  out  OUT_BITS  signed Ix*It.
- yt_out  out  OUT_BITS  signed Iy*It.
- valid_out  out  1  output registers hold a real pixel.
- sof_out  out  1  output pixel is frame pixel (0,0).
- eol_out  out  1  output pixel is the last column of a line.

Behaviour:
- Reset: all outputs 0; valid pipeline cleared; col=0; row=0. Reset has priority over en. Reset mid-frame discards all in-flight pixels; the next enabled pixel is taken as (0,0).
- Position counters advance only on en=1:
  - col increments each pixel; at FRAME_WIDTH-1 it wraps to 0 and row increments.
  - row wraps to 0 after FRAME_HEIGHT-1 with col wrap. Both wrap in the same cycle at the last pixel.
- Pipeline has 3 stages, all clock-enabled by en. With en=0 every register, including valid, holds its value.
  - S1: register t/x/y, col, row; valid bit set to 1.
  - S2: five signed multiplies, full 2*IN_BITS precision.
  - S3: arithmetic shift right by SHIFT (floor toward -inf), saturate to OUT_BITS ([-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]), border mask, register to outputs.
- Latency: a pixel accepted on enabled cycle N appears on the outputs after the 3rd enabled clock, i.e. after 3 en pulses. The en pattern does not affect the data.
- valid_out rises after the 3rd enabled cycle following reset. Gaps in en do not drop it.
- sof_out/eol_out are carried through the pipeline and are aligned with their pixel's data.
- Squares (xx, yy) are never negative before saturation. The cross products may be negative.
- Border mask: if col<BORDER or col>=FRAME_WIDTH-BORDER or row<BORDER or row>=FRAME_HEIGHT-BORDER, all five outputs are 0. valid_out, sof_out and eol_out are unaffected.

Optional Feature:
- Macro TENSOR_SATURATE_EN.
- Defined: S3 saturates as above.
- Undefined: S3 truncates the shifted product to its low OUT_BITS (two's-complement wrap). This saves area where SHIFT/OUT_BITS guarantee no overflow.
- Border mask, latency and flags are identical in both builds.

Decomposition:
- Shared package optical_flow_pkg:
  - Widths IN_BITS, OUT_BITS, SHIFT, BORDER and the frame dimensions.
  - typedef grad_t (signed IN_BITS), typedef prod_t (signed OUT_BITS).
  - struct tensor_t containing the five prod_t fields.
- One natural sub-module: scale_sat. It is instantiated 5 times and does shift-then-saturate/truncate for one product, with the macro handled there.

Test Plan:
- Reset then en=1 for 3 cycles with x=10, y=-3, t=4, BORDER=0, SHIFT=0 → third enabled edge gives xx=100, xy=-30, yy=9, xt=40, yt=-12, valid_out=1, sof_out=1.
- Same stimulus with en toggling 1,0,0,1,0,1 → identical outputs, appearing only after the 3rd en pulse; outputs hold during en=0.
- x=-2048, y=-2048, SHIFT=0, OUT_BITS=16, TENSOR_SATURATE_EN defined → xx=yy=xy=32767. Undefined → xx=0 (4194304 mod 2^16).
- x=-1, t=1, SHIFT=1 → xt=-1 (floor), not 0.
- Full 8x6 frame, FRAME_WIDTH=8, FRAME_HEIGHT=6, BORDER=1, all inputs 5:
  - Outputs are 25 only for col 1..6 and row 1..4, 0 elsewhere.
  - eol_out is set on every 8th valid pixel; sof_out recurs on the 49th pixel.
- Assert rst at pixel (3,2) mid-frame, then stream 3 pixels → valid_out low until the 3rd new pixel, and that pixel carries sof_out=1.
